// File: rtl/sort8_stream_io_if.sv
// Valid/ready stream bundle for sort8_stream_io.
// The input side carries words in and the output side carries sorted words out.
interface sort8_stream_io_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort8_stream_io.sv
// Serial stream wrapper around the combinational 8-way sorter.
// It gathers eight words, captures the sorter result, then drains that result smallest-first.
module sort8_stream_io #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sort8_stream_io_if.slave strm,
    output logic [W-1:0]     sort_a,
    output logic [W-1:0]     sort_b,
    output logic [W-1:0]     sort_c,
    output logic [W-1:0]     sort_d,
    output logic [W-1:0]     sort_e,
    output logic [W-1:0]     sort_f,
    output logic [W-1:0]     sort_g,
    output logic [W-1:0]     sort_h,
    input  logic [W-1:0]     sort_y0,
    input  logic [W-1:0]     sort_y1,
    input  logic [W-1:0]     sort_y2,
    input  logic [W-1:0]     sort_y3,
    input  logic [W-1:0]     sort_y4,
    input  logic [W-1:0]     sort_y5,
    input  logic [W-1:0]     sort_y6,
    input  logic [W-1:0]     sort_y7,
    output logic             busy
);

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [2:0]   fill_cnt;
    logic [2:0]   drain_idx;
    logic [W-1:0] slot [8];
    logic [W-1:0] res  [8];

    logic         in_ready_c;
    logic         out_valid_c;
    logic         out_last_c;
    logic [W-1:0] out_data_c;
    logic         in_acc;
    logic         out_acc;

    assign in_acc  = strm.in_valid && in_ready_c;
    assign out_acc = out_valid_c && strm.out_ready;

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        out_data_c  = '0;
        case (state)
            FILL: begin
                in_ready_c = 1'b1;
                if (strm.in_valid && fill_cnt == 3'd7)
                    state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = DRAIN;
            DRAIN: begin
                // Output comes only from the result registers, never straight from sort_y*.
                out_valid_c = 1'b1;
                out_data_c  = res[drain_idx];
                out_last_c  = (drain_idx == 3'd7);
                if (strm.out_ready && drain_idx == 3'd7)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            drain_idx <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                slot[i] <= '0;
                res[i]  <= '0;
            end
        end else begin
            state <= state_nxt;
            if (in_acc) begin
                slot[fill_cnt] <= strm.in_data;
                fill_cnt       <= fill_cnt + 3'd1;
            end
            if (state == CAPTURE) begin
                res[0] <= sort_y0;
                res[1] <= sort_y1;
                res[2] <= sort_y2;
                res[3] <= sort_y3;
                res[4] <= sort_y4;
                res[5] <= sort_y5;
                res[6] <= sort_y6;
                res[7] <= sort_y7;
            end
            if (out_acc)
                drain_idx <= drain_idx + 3'd1;
        end
    end

    assign strm.in_ready  = in_ready_c;
    assign strm.out_valid = out_valid_c;
    assign strm.out_data  = out_data_c;
    assign strm.out_last  = out_last_c;

    assign busy = (state != FILL) || (fill_cnt != 3'd0);

    assign sort_a = slot[0];
    assign sort_b = slot[1];
    assign sort_c = slot[2];
    assign sort_d = slot[3];
    assign sort_e = slot[4];
    assign sort_f = slot[5];
    assign sort_g = slot[6];
    assign sort_h = slot[7];

endmodule
